// File: rtl/rgb_button_if.sv
// Button-side signal bundle between the debounced button reader and its
// consumers (RGB LED driver, or a bench standing in for the board).
interface rgb_button_if;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [1:0] colour_sel;
  logic       led_en;

  // Reader side: samples the raw pin, drives the debounced status and selections
  modport master (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output colour_sel,
    output led_en
  );

  // Consumer side: owns the raw pin, observes status and selections
  modport slave (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  colour_sel,
    input  led_en
  );
endinterface

// File: rtl/rgb_button_in.sv
// Debounced push-button reader for the RGB demo. Synchronises the raw pin,
// debounces press and release with a four-state FSM, produces press /
// release / long-press strobes, and owns the colour selection and LED enable
// consumed by the LED driver. A short press cycles the colour; a long press
// toggles the LED enable and suppresses the colour advance on its release.
module rgb_button_in #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int CNT_W           = 28
) (
  input  logic         clk,
  input  logic         nrst,
  rgb_button_if.master btn
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_DN  = 2'd1,
    PRESSED = 2'd2,
    ARM_UP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TRIG = CNT_W'(LONG_CYCLES - 1);

  // Hold counter increment that parks at LONG_CYCLES instead of wrapping,
  // so a button held indefinitely can never re-trigger the long press.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LONG_MAX) ? v : v + CNT_ONE;
  endfunction

  // Colour rotation RED -> GREEN -> BLUE -> RED; any stray code recovers to RED.
  function automatic logic [1:0] next_colour(input logic [1:0] c);
    case (c)
      2'd1:    return 2'd2;
      2'd2:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  logic             btn_meta_p0;
  logic             btn_sync;
  state_t           state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt;
  logic             long_done;
  logic             long_fire;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic [1:0]       colour_q;
  logic             led_en_q;

  // Two-flop synchroniser: the only logic that touches the asynchronous pin
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_meta_p0 <= 1'b0;
      btn_sync    <= 1'b0;
    end else begin
      btn_meta_p0 <= btn.btn_raw;
      btn_sync    <= btn_meta_p0;
    end
  end

  // Long press fires once when the hold count crosses LONG_CYCLES-1
  assign long_fire = ((state == PRESSED) || (state == ARM_UP)) &&
                     (hcnt == LONG_TRIG) && !long_done;

  // Debounce FSM with hold counter, strobes and selection registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      dcnt      <= '0;
      hcnt      <= '0;
      long_done <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      colour_q  <= 2'd1;
      led_en_q  <= 1'b1;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      if ((state == PRESSED) || (state == ARM_UP)) begin
        hcnt <= sat_inc(hcnt);
      end

      if (long_fire) begin
        long_q    <= 1'b1;
        led_en_q  <= ~led_en_q;
        long_done <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (btn_sync) begin
            state <= ARM_DN;
            dcnt  <= CNT_ONE;
          end
        end
        ARM_DN: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (dcnt == DEB_MAX) begin
            state     <= PRESSED;
            press_q   <= 1'b1;
            level_q   <= 1'b1;
            hcnt      <= '0;
            long_done <= 1'b0;
          end else begin
            dcnt <= dcnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state <= ARM_UP;
            dcnt  <= CNT_ONE;
          end
        end
        ARM_UP: begin
          if (btn_sync) begin
            // Release bounce: resume the press without disturbing the hold count
            state <= PRESSED;
          end else if (dcnt == DEB_MAX) begin
            state     <= IDLE;
            release_q <= 1'b1;
            level_q   <= 1'b0;
            // A long press landing on this same edge still counts as long
            if (!long_done && !long_fire) begin
              colour_q <= next_colour(colour_q);
            end
          end else begin
            dcnt <= dcnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;
  assign btn.colour_sel    = colour_q;
  assign btn.led_en        = led_en_q;

endmodule

// File: tb/tb_rgb_button_in.sv
// Directed bench for rgb_button_in with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rgb_button_in;

  logic clk;
  logic nrst;
  int   ncmp;
  int   nerr;
  int   n_press;
  int   n_release;
  int   n_long;

  rgb_button_if bif ();

  rgb_button_in #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (8)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .btn (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe tallies, taken mid-cycle after outputs settle
  always begin
    @(posedge clk);
    #3;
    if (bif.press_pulse)   n_press++;
    if (bif.release_pulse) n_release++;
    if (bif.long_pulse)    n_long++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst        = 1'b0;
    bif.btn_raw = 1'b0;
    cyc(3);
    nrst = 1'b1;
    cyc(1);
  endtask

  task automatic short_press();
    bif.btn_raw = 1'b1;
    cyc(10);
    bif.btn_raw = 1'b0;
    cyc(10);
  endtask

  initial begin
    int p0, r0, l0;
    ncmp      = 0;
    nerr      = 0;
    n_press   = 0;
    n_release = 0;
    n_long    = 0;
    nrst        = 1'b0;
    bif.btn_raw = 1'b0;
    cyc(2);

    // Reset values
    chk("rst_level",   bif.btn_level,     1'b0);
    chk("rst_press",   bif.press_pulse,   1'b0);
    chk("rst_release", bif.release_pulse, 1'b0);
    chk("rst_long",    bif.long_pulse,    1'b0);
    chk("rst_colour",  bif.colour_sel,    2'd1);
    chk("rst_led_en",  bif.led_en,        1'b1);
    nrst = 1'b1;
    cyc(1);

    // 1: clean press held 10 cycles, then release
    bif.btn_raw = 1'b1;
    cyc(6);
    chk("t1_press_early", bif.press_pulse, 1'b0);
    cyc(1);
    chk("t1_press",       bif.press_pulse, 1'b1);
    chk("t1_level_hi",    bif.btn_level,   1'b1);
    cyc(1);
    chk("t1_press_1cyc",  bif.press_pulse, 1'b0);
    cyc(2);
    bif.btn_raw = 1'b0;
    cyc(6);
    chk("t1_rel_early",   bif.release_pulse, 1'b0);
    chk("t1_level_held",  bif.btn_level,     1'b1);
    cyc(1);
    chk("t1_release",     bif.release_pulse, 1'b1);
    chk("t1_level_lo",    bif.btn_level,     1'b0);
    chk("t1_colour",      bif.colour_sel,    2'd2);
    chk("t1_led_en",      bif.led_en,        1'b1);
    cyc(1);
    chk("t1_rel_1cyc",    bif.release_pulse, 1'b0);
    chk("t1_no_long",     n_long,            0);

    // 2: bounces too short to be accepted
    do_reset();
    p0 = n_press;
    r0 = n_release;
    bif.btn_raw = 1'b1;
    cyc(3);
    bif.btn_raw = 1'b0;
    cyc(1);
    bif.btn_raw = 1'b1;
    cyc(2);
    bif.btn_raw = 1'b0;
    cyc(10);
    chk("t2_no_press",   n_press - p0,   0);
    chk("t2_no_release", n_release - r0, 0);
    chk("t2_level",      bif.btn_level,  1'b0);
    chk("t2_colour",     bif.colour_sel, 2'd1);

    // 3: 2-cycle low glitch during a held press
    do_reset();
    p0 = n_press;
    r0 = n_release;
    l0 = n_long;
    bif.btn_raw = 1'b1;
    cyc(7);
    chk("t3_press", bif.press_pulse, 1'b1);
    cyc(3);
    bif.btn_raw = 1'b0;
    cyc(2);
    bif.btn_raw = 1'b1;
    cyc(10);
    chk("t3_one_press",  n_press - p0,   1);
    chk("t3_no_release", n_release - r0, 0);
    chk("t3_level",      bif.btn_level,  1'b1);
    chk("t3_no_long",    n_long - l0,    0);

    // 4: three short presses rotate the colour
    do_reset();
    short_press();
    chk("t4_colour_a", bif.colour_sel, 2'd2);
    short_press();
    chk("t4_colour_b", bif.colour_sel, 2'd3);
    short_press();
    chk("t4_colour_c", bif.colour_sel, 2'd1);

    // 5: long press toggles LED enable, release keeps colour
    do_reset();
    l0 = n_long;
    bif.btn_raw = 1'b1;
    cyc(7);
    chk("t5_press", bif.press_pulse, 1'b1);
    cyc(19);
    chk("t5_long_early", bif.long_pulse, 1'b0);
    chk("t5_led_early",  bif.led_en,     1'b1);
    cyc(1);
    chk("t5_long",       bif.long_pulse, 1'b1);
    chk("t5_led_off",    bif.led_en,     1'b0);
    cyc(1);
    chk("t5_long_1cyc",  bif.long_pulse, 1'b0);
    cyc(12);
    bif.btn_raw = 1'b0;
    cyc(7);
    chk("t5_release",    bif.release_pulse, 1'b1);
    chk("t5_colour",     bif.colour_sel,    2'd1);
    chk("t5_led_kept",   bif.led_en,        1'b0);
    chk("t5_long_once",  n_long - l0,       1);
    cyc(3);
    bif.btn_raw = 1'b1;
    cyc(27);
    chk("t5_long2",      bif.long_pulse, 1'b1);
    chk("t5_led_on",     bif.led_en,     1'b1);
    cyc(5);
    bif.btn_raw = 1'b0;
    cyc(8);
    chk("t5_colour2",    bif.colour_sel, 2'd1);
    chk("t5_long_twice", n_long - l0,    2);

    // 5b: release strobe on the same edge as the long strobe
    bif.btn_raw = 1'b1;
    cyc(7);
    chk("t5b_press", bif.press_pulse, 1'b1);
    cyc(13);
    bif.btn_raw = 1'b0;
    cyc(7);
    chk("t5b_release", bif.release_pulse, 1'b1);
    chk("t5b_long",    bif.long_pulse,    1'b1);
    chk("t5b_colour",  bif.colour_sel,    2'd1);
    chk("t5b_led",     bif.led_en,        1'b0);

    // 6: reset while debouncing a release with colour 3
    do_reset();
    short_press();
    short_press();
    r0 = n_release;
    bif.btn_raw = 1'b1;
    cyc(10);
    bif.btn_raw = 1'b0;
    cyc(4);
    chk("t6_pre_colour", bif.colour_sel, 2'd3);
    chk("t6_pre_level",  bif.btn_level,  1'b1);
    nrst = 1'b0;
    #1;
    chk("t6_colour",  bif.colour_sel,    2'd1);
    chk("t6_led_en",  bif.led_en,        1'b1);
    chk("t6_level",   bif.btn_level,     1'b0);
    chk("t6_release", bif.release_pulse, 1'b0);
    chk("t6_press",   bif.press_pulse,   1'b0);
    bif.btn_raw = 1'b1;
    cyc(4);
    chk("t6_no_release", n_release - r0, 0);
    nrst = 1'b1;
    cyc(6);
    chk("t6_held_early", bif.press_pulse, 1'b0);
    cyc(1);
    chk("t6_held_press", bif.press_pulse, 1'b1);
    bif.btn_raw = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
